// File: rtl/spram_access_ctrl.sv
// Requester-side controller for a single-port RAM: post-reset clear sweep, then a
// valid/ready request stream with fixed-latency read responses and parity-fault tracking.
module spram_access_ctrl #(
    parameter int unsigned           ADDR_WIDTH    = 4,
    parameter int unsigned           DATA_WIDTH    = 32,
    parameter int unsigned           READ_LATENCY  = 1,
    parameter bit                    INIT_ON_RESET = 1'b1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE    = '0
) (
    input  logic                  clka,
    input  logic                  rsta,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  init_done,
    output logic [7:0]            err_cnt,
    output logic [ADDR_WIDTH-1:0] err_addr,
    output logic                  ram_ena,
    output logic                  ram_wea,
    output logic [ADDR_WIDTH-1:0] ram_addra,
    output logic [DATA_WIDTH-1:0] ram_dina,
    input  logic [DATA_WIDTH-1:0] ram_douta,
    input  logic                  ram_parity_err
);

    typedef enum logic {StInit, StRun} state_e;

    state_e                                   state_q, state_d;
    logic [ADDR_WIDTH-1:0]                    cnt_q, cnt_d;
    logic [READ_LATENCY-1:0]                  vld_q;
    logic [READ_LATENCY-1:0][ADDR_WIDTH-1:0]  addr_q;
    logic [7:0]                               err_cnt_q, err_cnt_d;
    logic [ADDR_WIDTH-1:0]                    err_addr_q, err_addr_d;
    logic                                     accept;
    logic                                     tail_vld;
    logic                                     tail_err;

    // Next-state and RAM drive; every output is held at zero while reset is asserted.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_ready = 1'b0;
        ram_ena   = 1'b0;
        ram_wea   = 1'b0;
        ram_addra = '0;
        ram_dina  = '0;
        if (!rsta) begin
            unique case (state_q)
                StInit: begin
                    ram_ena   = 1'b1;
                    ram_wea   = 1'b1;
                    ram_addra = cnt_q;
                    ram_dina  = INIT_VALUE;
                    // Counter stops at the last address; the FSM leaves INIT instead of wrapping.
                    if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
                        state_d = StRun;
                    end else begin
                        cnt_d = cnt_q + ADDR_WIDTH'(1);
                    end
                end
                StRun: begin
                    req_ready = 1'b1;
                    ram_ena   = req_valid;
                    ram_wea   = req_we;
                    ram_addra = req_addr;
                    ram_dina  = req_wdata;
                end
                default: state_d = StInit;
            endcase
        end
    end

    assign accept = req_valid & req_ready;

    // FSM state and sweep counter.
    always_ff @(posedge clka) begin
        if (rsta) begin
            state_q <= INIT_ON_RESET ? StInit : StRun;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Read-tag pipeline: tail lines up with the RAM's returned data.
    always_ff @(posedge clka) begin
        if (rsta) begin
            vld_q  <= '0;
            addr_q <= '0;
        end else begin
            vld_q[0]  <= accept & ~req_we;
            addr_q[0] <= req_addr;
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                vld_q[i]  <= vld_q[i-1];
                addr_q[i] <= addr_q[i-1];
            end
        end
    end

    assign tail_vld = vld_q[READ_LATENCY-1] & ~rsta;
    assign tail_err = tail_vld & ram_parity_err;

    // Parity-fault counter (saturating) and first-fault address capture.
    always_comb begin
        err_cnt_d  = err_cnt_q;
        err_addr_d = err_addr_q;
        if (tail_err) begin
            if (err_cnt_q == 8'd0) begin
                err_addr_d = addr_q[READ_LATENCY-1];
            end
            if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    // Fault-tracking registers.
    always_ff @(posedge clka) begin
        if (rsta) begin
            err_cnt_q  <= '0;
            err_addr_q <= '0;
        end else begin
            err_cnt_q  <= err_cnt_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign rsp_valid = tail_vld;
    assign rsp_rdata = tail_vld ? ram_douta : '0;
    assign rsp_err   = tail_err;
    assign init_done = ~rsta & (state_q == StRun);
    assign err_cnt   = err_cnt_q;
    assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_spram_access_ctrl.sv
// Bench for spram_access_ctrl: two instances (latency 2 with init sweep, latency 3 without),
// each driving a behavioural RAM model with injectable parity faults.
module tb_spram_access_ctrl;

    localparam int LAT_A = 2;
    localparam int LAT_B = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Instance A signals
    logic        rst_a, valid_a, ready_a, we_a, rsp_valid_a, rsp_err_a, init_done_a;
    logic [3:0]  addr_a, err_addr_a, ram_addra_a;
    logic [31:0] wdata_a, rsp_rdata_a, ram_dina_a, ram_douta_a;
    logic [7:0]  err_cnt_a;
    logic        ram_ena_a, ram_wea_a, ram_perr_a, perr_inj_a;

    // Instance B signals
    logic        rst_b, valid_b, ready_b, we_b, rsp_valid_b, rsp_err_b, init_done_b;
    logic [3:0]  addr_b, err_addr_b, ram_addra_b;
    logic [31:0] wdata_b, rsp_rdata_b, ram_dina_b, ram_douta_b;
    logic [7:0]  err_cnt_b;
    logic        ram_ena_b, ram_wea_b, ram_perr_b, perr_inj_b;

    spram_access_ctrl #(
        .ADDR_WIDTH(4), .DATA_WIDTH(32), .READ_LATENCY(LAT_A),
        .INIT_ON_RESET(1'b1), .INIT_VALUE(32'h0)
    ) dut_a (
        .clka(clk), .rsta(rst_a), .req_valid(valid_a), .req_ready(ready_a), .req_we(we_a),
        .req_addr(addr_a), .req_wdata(wdata_a), .rsp_valid(rsp_valid_a),
        .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a), .init_done(init_done_a),
        .err_cnt(err_cnt_a), .err_addr(err_addr_a), .ram_ena(ram_ena_a), .ram_wea(ram_wea_a),
        .ram_addra(ram_addra_a), .ram_dina(ram_dina_a), .ram_douta(ram_douta_a),
        .ram_parity_err(ram_perr_a)
    );

    spram_access_ctrl #(
        .ADDR_WIDTH(4), .DATA_WIDTH(32), .READ_LATENCY(LAT_B),
        .INIT_ON_RESET(1'b0), .INIT_VALUE(32'h0)
    ) dut_b (
        .clka(clk), .rsta(rst_b), .req_valid(valid_b), .req_ready(ready_b), .req_we(we_b),
        .req_addr(addr_b), .req_wdata(wdata_b), .rsp_valid(rsp_valid_b),
        .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b), .init_done(init_done_b),
        .err_cnt(err_cnt_b), .err_addr(err_addr_b), .ram_ena(ram_ena_b), .ram_wea(ram_wea_b),
        .ram_addra(ram_addra_b), .ram_dina(ram_dina_b), .ram_douta(ram_douta_b),
        .ram_parity_err(ram_perr_b)
    );

    // RAM models: parity flag is delayed independently of reads so untagged faults can occur.
    logic [31:0] mem_a [16];
    logic [31:0] dq_a  [LAT_A];
    logic        pq_a  [LAT_A];
    logic [31:0] mem_b [16];
    logic [31:0] dq_b  [LAT_B];
    logic        pq_b  [LAT_B];

    always @(posedge clk) begin
        if (ram_ena_a && ram_wea_a) mem_a[ram_addra_a] <= ram_dina_a;
        dq_a[0] <= (ram_ena_a && !ram_wea_a) ? mem_a[ram_addra_a] : 32'h0BAD_0BAD;
        pq_a[0] <= perr_inj_a;
        for (int i = 1; i < LAT_A; i++) begin
            dq_a[i] <= dq_a[i-1];
            pq_a[i] <= pq_a[i-1];
        end
    end
    assign ram_douta_a = dq_a[LAT_A-1];
    assign ram_perr_a  = pq_a[LAT_A-1];

    always @(posedge clk) begin
        if (ram_ena_b && ram_wea_b) mem_b[ram_addra_b] <= ram_dina_b;
        dq_b[0] <= (ram_ena_b && !ram_wea_b) ? mem_b[ram_addra_b] : 32'h0BAD_0BAD;
        pq_b[0] <= perr_inj_b;
        for (int i = 1; i < LAT_B; i++) begin
            dq_b[i] <= dq_b[i-1];
            pq_b[i] <= pq_b[i-1];
        end
    end
    assign ram_douta_b = dq_b[LAT_B-1];
    assign ram_perr_b  = pq_b[LAT_B-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // One record per cycle: request inputs and the response expected in that same cycle.
    typedef struct {
        logic        vld;
        logic        we;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic        perr;
        logic        e_vld;
        logic [31:0] e_data;
        logic        e_err;
    } vec_t;

    vec_t tbl [12];
    int   b_writes;

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 4'd3, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0,         1'b0};
        tbl[1]  = '{1'b1, 1'b0, 4'd3, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0};
        tbl[2]  = '{1'b1, 1'b1, 4'd5, 32'h5555_5555, 1'b0, 1'b0, 32'h0,         1'b0};
        tbl[3]  = '{1'b1, 1'b0, 4'd5, 32'h0,         1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 4'd9, 32'h9999_9999, 1'b0, 1'b0, 32'h0,         1'b0};
        tbl[5]  = '{1'b1, 1'b0, 4'd9, 32'h0,         1'b1, 1'b1, 32'h5555_5555, 1'b1};
        tbl[6]  = '{1'b1, 1'b0, 4'd0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0};
        tbl[7]  = '{1'b0, 1'b0, 4'd0, 32'h0,         1'b0, 1'b1, 32'h9999_9999, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 4'd7, 32'h0,         1'b0, 1'b1, 32'h0,         1'b0};
        tbl[9]  = '{1'b0, 1'b0, 4'd0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0};
        tbl[10] = '{1'b0, 1'b0, 4'd0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0};
        tbl[11] = '{1'b0, 1'b0, 4'd0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0};

        rst_a = 1'b1; valid_a = 1'b0; we_a = 1'b0; addr_a = '0; wdata_a = '0; perr_inj_a = 1'b0;
        rst_b = 1'b1; valid_b = 1'b0; we_b = 1'b0; addr_b = '0; wdata_b = '0; perr_inj_b = 1'b0;

        // Outputs while reset is held
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ena", {31'b0, ram_ena_a}, 32'd0);
        chk("rst_ready", {31'b0, ready_a}, 32'd0);
        chk("rst_init_done", {31'b0, init_done_a}, 32'd0);
        chk("rst_rsp_valid", {31'b0, rsp_valid_a}, 32'd0);
        chk("rst_err_cnt", {24'b0, err_cnt_a}, 32'd0);
        chk("rst_b_init_done", {31'b0, init_done_b}, 32'd0);

        // Release both; A sweeps, B starts directly in RUN
        @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
        #1;
        chk("b_init_done_first", {31'b0, init_done_b}, 32'd1);
        chk("b_ready_first", {31'b0, ready_b}, 32'd1);
        b_writes = 0;
        for (int k = 0; k < 16; k++) begin
            if (k > 0) begin
                @(negedge clk);
                #1;
            end
            chk("sweep_ena", {31'b0, ram_ena_a}, 32'd1);
            chk("sweep_wea", {31'b0, ram_wea_a}, 32'd1);
            chk("sweep_addr", {28'b0, ram_addra_a}, k);
            chk("sweep_dina", ram_dina_a, 32'd0);
            chk("sweep_ready", {31'b0, ready_a}, 32'd0);
            chk("sweep_init_done", {31'b0, init_done_a}, 32'd0);
            if (ram_ena_b) b_writes++;
        end
        @(negedge clk);
        #1;
        chk("init_done_c17", {31'b0, init_done_a}, 32'd1);
        chk("ready_c17", {31'b0, ready_a}, 32'd1);
        chk("b_no_writes", b_writes, 32'd0);

        // Table-driven traffic on A (latency 2)
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            valid_a = tbl[i].vld; we_a = tbl[i].we; addr_a = tbl[i].addr;
            wdata_a = tbl[i].wdata; perr_inj_a = tbl[i].perr;
            #1;
            chk($sformatf("v%0d_ena", i), {31'b0, ram_ena_a}, {31'b0, tbl[i].vld});
            if (tbl[i].vld) begin
                chk($sformatf("v%0d_addr", i), {28'b0, ram_addra_a}, {28'b0, tbl[i].addr});
                chk($sformatf("v%0d_wea", i), {31'b0, ram_wea_a}, {31'b0, tbl[i].we});
                chk($sformatf("v%0d_dina", i), ram_dina_a, tbl[i].wdata);
            end
            chk($sformatf("v%0d_rsp_valid", i), {31'b0, rsp_valid_a}, {31'b0, tbl[i].e_vld});
            chk($sformatf("v%0d_rsp_rdata", i), rsp_rdata_a, tbl[i].e_data);
            chk($sformatf("v%0d_rsp_err", i), {31'b0, rsp_err_a}, {31'b0, tbl[i].e_err});
        end
        chk("err_cnt_two", {24'b0, err_cnt_a}, 32'd2);
        chk("err_addr_first", {28'b0, err_addr_a}, 32'd5);

        // 300 more faulted reads: counter must saturate, first address must hold
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            valid_a = 1'b1; we_a = 1'b0; addr_a = 4'(i); perr_inj_a = 1'b1;
        end
        @(negedge clk);
        valid_a = 1'b0; perr_inj_a = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("err_cnt_sat", {24'b0, err_cnt_a}, 32'd255);
        chk("err_addr_hold", {28'b0, err_addr_a}, 32'd5);

        // Reset with two reads in flight
        @(negedge clk);
        valid_a = 1'b1; we_a = 1'b0; addr_a = 4'd3; perr_inj_a = 1'b0;
        @(negedge clk);
        addr_a = 4'd5; perr_inj_a = 1'b1;
        @(negedge clk);
        valid_a = 1'b0; perr_inj_a = 1'b0; rst_a = 1'b1;
        #1;
        chk("t5_rst_rsp_valid", {31'b0, rsp_valid_a}, 32'd0);
        chk("t5_rst_ena", {31'b0, ram_ena_a}, 32'd0);
        @(negedge clk);
        rst_a = 1'b0;
        #1;
        chk("t5_rsp_valid_0", {31'b0, rsp_valid_a}, 32'd0);
        chk("t5_err_cnt", {24'b0, err_cnt_a}, 32'd0);
        chk("t5_err_addr", {28'b0, err_addr_a}, 32'd0);
        chk("t5_sweep_ena", {31'b0, ram_ena_a}, 32'd1);
        chk("t5_sweep_addr0", {28'b0, ram_addra_a}, 32'd0);
        chk("t5_ready", {31'b0, ready_a}, 32'd0);
        for (int k = 1; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk("t5_rsp_valid_k", {31'b0, rsp_valid_a}, 32'd0);
            chk("t5_sweep_addr_k", {28'b0, ram_addra_a}, k);
            chk("t5_err_cnt_k", {24'b0, err_cnt_a}, 32'd0);
        end
        // Reset mid-sweep restarts at address 0
        @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        #1;
        chk("sweep_restart_addr", {28'b0, ram_addra_a}, 32'd0);
        chk("sweep_restart_ena", {31'b0, ram_ena_a}, 32'd1);

        // B (latency 3): write @0..7, then back-to-back reads @0..7
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            valid_b = 1'b1; we_b = 1'b1; addr_b = 4'(i); wdata_b = 32'hB000_0000 + i;
            #1;
            chk("b_wr_rsp_valid", {31'b0, rsp_valid_b}, 32'd0);
        end
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            if (c < 8) begin
                valid_b = 1'b1; we_b = 1'b0; addr_b = 4'(c);
            end else begin
                valid_b = 1'b0; we_b = 1'b0;
            end
            #1;
            if (c >= LAT_B && c < LAT_B + 8) begin
                chk($sformatf("b_rd%0d_valid", c - LAT_B), {31'b0, rsp_valid_b}, 32'd1);
                chk($sformatf("b_rd%0d_data", c - LAT_B), rsp_rdata_b,
                    32'hB000_0000 + (c - LAT_B));
            end else begin
                chk($sformatf("b_c%0d_idle", c), {31'b0, rsp_valid_b}, 32'd0);
                chk($sformatf("b_c%0d_rdata0", c), rsp_rdata_b, 32'd0);
            end
        end
        chk("b_err_cnt", {24'b0, err_cnt_b}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
